mips_multicycle_ctrl: RTL
=========================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Multi-cycle MIPS control unit, successor to the single-cycle decoder. Sequences each instruction
//  through FETCH/DECODE/EXEC/MEM/WB states, stalls on a memory ready handshake and traps on illegal
//  opcodes or bus timeout. Counts retired instructions. Drives a shared-ALU, single-memory datapath.
// PARAMETERS
//  OPW        6   opcode width (Inst[31:26])
//  CNTW       32  retired-instruction counter width
//  MEM_TMO    16  max wait cycles for mem_ready before trap; 0 = wait forever
//  HAS_ADDI   1   1: ADDI (0x08) legal; 0: ADDI traps
// PORTS
//  clk         in   1     clock, rising edge
//  reset       in   1     synchronous, active-low reset
//  run         in   1     1: leave FETCH and start next instruction; 0: hold in FETCH
//  opcode      in   OPW   IR[31:26], valid from DECODE onward
//  zero        in   1     ALU zero flag (BEQ)
//  mem_ready   in   1     memory completes current MemRead/MemWrite this cycle
//  PCWrite     out  1     unconditional PC load
//  PCWriteCond out  1     PC load if zero
//  IorD        out  1     0: mem addr = PC, 1: ALUOut
//  MemRead     out  1     memory read request (held until mem_ready)
//  MemWrite    out  1     memory write request (held until mem_ready)
//  IRWrite     out  1     load instruction register
//  MemtoReg    out  1     reg write data: 0 ALUOut, 1 MDR
//  RegDst      out  1     dest reg: 0 rt, 1 rd
//  RegWrite    out  1     register file write
//  ALUSrcA     out  1     0: PC, 1: rs
//  ALUSrcB     out  2     00 rt, 01 const 4, 10 signext, 11 signext<<2
//  ALUOp       out  2     00 add, 01 sub, 10 funct
//  PCSource    out  2     00 ALU, 01 ALUOut, 10 jump target
//  trap        out  1     sticky: illegal opcode or bus timeout
//  retired     out  CNTW  instructions completed since reset
// BEHAVIOUR
//  Reset (reset==0 at edge): state=FETCH, wait counter=0, trap=0, retired=0; all strobes 0 while reset low.
//  States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPE, RTWB, BRANCH, JUMP, ADDIEX, ADDIWB, TRAP.
//  FETCH: if run: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite and PCWrite
//   asserted only in the cycle mem_ready=1, then ->DECODE. run=0: all strobes 0, stay.
//  DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target to ALUOut). Dispatch on opcode:
//   0x23/0x2B->MEMADR, 0x00->RTYPE, 0x04->BRANCH, 0x02->JUMP, 0x08->ADDIEX (if HAS_ADDI), else->TRAP.
//  MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; ->MEMRD (LW) or MEMWR (SW).
//  MEMRD: MemRead=1, IorD=1; on mem_ready ->MEMWB. MEMWB: RegWrite=1, MemtoReg=1, RegDst=0 ->FETCH.
//  MEMWR: MemWrite=1, IorD=1; on mem_ready ->FETCH (retire).
//  RTYPE: ALUSrcA=1, ALUSrcB=00, ALUOp=10 ->RTWB. RTWB: RegWrite=1, RegDst=1, MemtoReg=0 ->FETCH.
//  BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 ->FETCH.
//  JUMP: PCWrite=1, PCSource=10 ->FETCH. ADDIEX: as MEMADR ->ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0 ->FETCH.
//  Latency with mem_ready tied 1: LW 5, SW 4, R 4, ADDI 4, BEQ 3, J 3 cycles.
//  retired +1 (wrapping mod 2^CNTW) on the cycle a final state exits to FETCH.
//  Wait counter: clears on entering any memory state; increments each cycle MemRead|MemWrite and
//   !mem_ready; if MEM_TMO!=0 and counter reaches MEM_TMO-1 without mem_ready -> TRAP next cycle.
//   mem_ready on that same cycle wins (no trap).
//  TRAP: all strobes 0, trap=1, stays until reset; retired frozen. Reset mid-instruction aborts
//   to FETCH without retiring. Unused opcode bits ignored only above OPW; no X propagation on outputs.
//  Outputs are Moore (state-decoded) except IRWrite/PCWrite in FETCH and state exits gated by mem_ready.
// STRUCTURE
//  Shared package mips_pkg: opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI),
//   ALUOp/ALUSrcB/PCSource encodings, state enum. One sub-module: mips_mem_wait_timer (wait counter +
//   timeout compare, parameter MEM_TMO). Next-state and output decode inline in this module.
// TESTING
//  1 reset low 3 cycles, release, run=1, mem_ready=1, opcode=0x00 -> FETCH,DECODE,RTYPE,RTWB; RegWrite=1,RegDst=1 in cycle 4; retired=1.
//  2 LW (0x23), mem_ready low 3 cycles in MEMRD -> MemRead,IorD held 3 extra cycles; MEMWB MemtoReg=1; total 8 cycles; retired+1.
//  3 BEQ (0x04) zero=1 -> PCWriteCond=1,PCSource=01 in cycle 3; J (0x02) -> PCWrite=1,PCSource=10 in cycle 3.
//  4 opcode=0x3F -> TRAP after DECODE; trap=1, strobes 0 for 20 cycles; reset -> trap=0, retired=0.
//  5 MEM_TMO=4, SW with mem_ready=0 -> trap=1 after 4 wait cycles; variant mem_ready=1 on 4th -> no trap, retire.
//  6 run=0 in FETCH -> no MemRead, no retire; CNTW=4, 17 J instructions -> retired=1 (wrap).

Source files
------------

// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, mux selects,
// FSM states and the bundled control word.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_SEXT    = 2'b10;
  localparam logic [1:0] SRCB_SEXT_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTYPE,
    S_RTWB, S_BRANCH, S_JUMP, S_ADDIEX, S_ADDIWB, S_TRAP
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle. master = controller, slave = datapath side.
interface mips_multicycle_ctrl_if #(
  parameter int OPW  = 6,
  parameter int CNTW = 32
);
  logic            run;
  logic [OPW-1:0]  opcode;
  logic            zero;
  logic            mem_ready;

  logic            PCWrite;
  logic            PCWriteCond;
  logic            IorD;
  logic            MemRead;
  logic            MemWrite;
  logic            IRWrite;
  logic            MemtoReg;
  logic            RegDst;
  logic            RegWrite;
  logic            ALUSrcA;
  logic [1:0]      ALUSrcB;
  logic [1:0]      ALUOp;
  logic [1:0]      PCSource;
  logic            trap;
  logic [CNTW-1:0] retired;

  modport master (
    input  run, opcode, zero, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, trap, retired
  );

  modport slave (
    output run, opcode, zero, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, trap, retired
  );
endinterface

// File: rtl/mips_multicycle_ctrl_wait_timer.sv
// Memory wait counter: counts stalled request cycles and flags a timeout on the
// last permitted stall cycle. MEM_TMO = 0 disables the timeout.
module mips_mem_wait_timer #(
  parameter int MEM_TMO = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic req_i,
  input  logic ready_i,
  output logic timeout_o
);
  localparam int CW = (MEM_TMO > 1) ? $clog2(MEM_TMO) : 1;
  localparam logic [CW-1:0] CMAX = (MEM_TMO == 0) ? {CW{1'b1}} : CW'(MEM_TMO - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Any non-stalled cycle clears, so every memory state is entered with a fresh count.
  always_comb begin
    cnt_d = '0;
    if (req_i && !ready_i && cnt_q != CMAX) cnt_d = cnt_q + 1'b1;
    else if (req_i && !ready_i)             cnt_d = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign timeout_o = (MEM_TMO != 0) && req_i && !ready_i && (cnt_q == CMAX);
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// stalls on mem_ready, traps on illegal opcode or bus timeout, counts retirements.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int OPW      = 6,
  parameter int CNTW     = 32,
  parameter int MEM_TMO  = 16,
  parameter int HAS_ADDI = 1
) (
  input logic                   clk,
  input logic                   reset,
  mips_multicycle_ctrl_if.master bus
);

  state_e          state_q, state_d;
  logic            trap_q, trap_d;
  logic [CNTW-1:0] ret_q, ret_d;
  logic            retire, mem_req, tmo;
  ctrl_t           ctl;

  function automatic logic is_op(input logic [OPW-1:0] op, input logic [5:0] code);
    return op == OPW'(code);
  endfunction

  assign mem_req = ctl.mem_read | ctl.mem_write;

  mips_mem_wait_timer #(.MEM_TMO(MEM_TMO)) u_wait (
    .clk      (clk),
    .reset    (reset),
    .req_i    (mem_req),
    .ready_i  (bus.mem_ready),
    .timeout_o(tmo)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
      trap_q  <= 1'b0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      trap_q  <= trap_d;
      ret_q   <= ret_d;
    end
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (bus.run) begin
          if (bus.mem_ready) state_d = S_DECODE;
          else if (tmo)      state_d = S_TRAP;
        end
      end
      S_DECODE: begin
        if (is_op(bus.opcode, OP_LW) || is_op(bus.opcode, OP_SW)) state_d = S_MEMADR;
        else if (is_op(bus.opcode, OP_RTYPE))                     state_d = S_RTYPE;
        else if (is_op(bus.opcode, OP_BEQ))                       state_d = S_BRANCH;
        else if (is_op(bus.opcode, OP_J))                         state_d = S_JUMP;
        else if (HAS_ADDI != 0 && is_op(bus.opcode, OP_ADDI))     state_d = S_ADDIEX;
        else                                                      state_d = S_TRAP;
      end
      S_MEMADR: state_d = is_op(bus.opcode, OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (bus.mem_ready) state_d = S_MEMWB;
        else if (tmo)      state_d = S_TRAP;
      end
      S_MEMWR: begin
        if (bus.mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else if (tmo) begin
          state_d = S_TRAP;
        end
      end
      S_RTYPE:  state_d = S_RTWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_RTWB, S_BRANCH, S_JUMP, S_ADDIWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_TRAP;
    endcase
  end

  assign trap_d = trap_q | (state_d == S_TRAP);
  assign ret_d  = retire ? ret_q + 1'b1 : ret_q;

  // Strobes are forced low while reset is held, independent of the stored state.
  always_comb begin
    ctl = '0;
    if (reset) begin
      unique case (state_q)
        S_FETCH: begin
          if (bus.run) begin
            ctl.mem_read  = 1'b1;
            ctl.alu_src_b = SRCB_FOUR;
            ctl.alu_op    = ALUOP_ADD;
            ctl.pc_source = PCSRC_ALU;
            ctl.ir_write  = bus.mem_ready;
            ctl.pc_write  = bus.mem_ready;
          end
        end
        S_DECODE: ctl.alu_src_b = SRCB_SEXT_SH;
        S_MEMADR, S_ADDIEX: begin
          ctl.alu_src_a = 1'b1;
          ctl.alu_src_b = SRCB_SEXT;
          ctl.alu_op    = ALUOP_ADD;
        end
        S_MEMRD: begin
          ctl.mem_read = 1'b1;
          ctl.iord     = 1'b1;
        end
        S_MEMWB: begin
          ctl.reg_write  = 1'b1;
          ctl.mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          ctl.mem_write = 1'b1;
          ctl.iord      = 1'b1;
        end
        S_RTYPE: begin
          ctl.alu_src_a = 1'b1;
          ctl.alu_src_b = SRCB_RT;
          ctl.alu_op    = ALUOP_FUNCT;
        end
        S_RTWB: begin
          ctl.reg_write = 1'b1;
          ctl.reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          ctl.alu_src_a     = 1'b1;
          ctl.alu_src_b     = SRCB_RT;
          ctl.alu_op        = ALUOP_SUB;
          ctl.pc_write_cond = 1'b1;
          ctl.pc_source     = PCSRC_ALUOUT;
        end
        S_JUMP: begin
          ctl.pc_write  = 1'b1;
          ctl.pc_source = PCSRC_JUMP;
        end
        S_ADDIWB: ctl.reg_write = 1'b1;
        default:  ctl = '0;
      endcase
    end
  end

  assign bus.PCWrite     = ctl.pc_write;
  assign bus.PCWriteCond = ctl.pc_write_cond;
  assign bus.IorD        = ctl.iord;
  assign bus.MemRead     = ctl.mem_read;
  assign bus.MemWrite    = ctl.mem_write;
  assign bus.IRWrite     = ctl.ir_write;
  assign bus.MemtoReg    = ctl.mem_to_reg;
  assign bus.RegDst      = ctl.reg_dst;
  assign bus.RegWrite    = ctl.reg_write;
  assign bus.ALUSrcA     = ctl.alu_src_a;
  assign bus.ALUSrcB     = ctl.alu_src_b;
  assign bus.ALUOp       = ctl.alu_op;
  assign bus.PCSource    = ctl.pc_source;
  assign bus.trap        = trap_q;
  assign bus.retired     = ret_q;

endmodule
